// File: rtl/mcm6576_dot_shifter.sv
// Dot serialiser that follows the MCM6576 character ROM. It steps the column address and
// row select, captures each 7-dot ROM row and shifts it out MSB-first with an inverse-video flag.
module mcm6576_dot_shifter #(
  parameter int unsigned DOTS_PER_CHAR  = 8,
  parameter int unsigned CHARS_PER_LINE = 48,
  parameter int unsigned ROWS_PER_CHAR  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic [6:0] rom_d,
  input  logic       inv,
  output logic [5:0] char_col,
  output logic [3:0] rs,
  output logic       load,
  output logic       video,
  output logic       video_active
);

  localparam int unsigned CntW = $clog2(DOTS_PER_CHAR);

  localparam logic [CntW-1:0] DotLast = CntW'(DOTS_PER_CHAR - 1);
  localparam logic [5:0]      ColLast = 6'(CHARS_PER_LINE - 1);
  localparam logic [3:0]      RowLast = 4'(ROWS_PER_CHAR - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                     state;
  logic [CntW-1:0]            dot_cnt;
  logic [DOTS_PER_CHAR-1:0]   shreg;
  logic [DOTS_PER_CHAR-1:0]   load_word;
  logic                       inv_q;
  logic                       dot_last;

  // ROM dots sit in the top bits; any extra dot positions form the blank gap.
  always_comb begin
    load_word = '0;
    load_word[DOTS_PER_CHAR-1 -: 7] = rom_d;
  end

  always_comb begin
    dot_last = (dot_cnt == DotLast);
    load     = (state == StRun) && dot_last;
  end

  assign video = video_active & (shreg[DOTS_PER_CHAR-1] ^ inv_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      dot_cnt      <= '0;
      shreg        <= '0;
      inv_q        <= 1'b0;
      char_col     <= '0;
      rs           <= '0;
      video_active <= 1'b0;
    end else begin
      if (frame_start) begin
        rs <= '0;
      end

      if (load) begin
        shreg        <= load_word;
        inv_q        <= inv;
        char_col     <= char_col + 6'd1;
        video_active <= 1'b1;
      end else begin
        shreg <= shreg << 1;
      end

      unique case (state)
        StIdle: begin
          dot_cnt <= '0;
          if (line_start) begin
            state <= StRun;
          end
        end
        StRun: begin
          dot_cnt <= dot_last ? '0 : dot_cnt + CntW'(1);
          if (load && (char_col == ColLast)) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (dot_last) begin
            state        <= StIdle;
            dot_cnt      <= '0;
            char_col     <= '0;
            video_active <= 1'b0;
            // A coincident frame_start keeps rs at zero.
            if (!frame_start) begin
              rs <= (rs == RowLast) ? 4'd0 : rs + 4'd1;
            end
          end else begin
            dot_cnt <= dot_cnt + CntW'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcm6576_dot_shifter.sv
// Bench for mcm6576_dot_shifter: hand-written line vectors, reset and back-to-back sequences,
// then random lines against a per-line dot-stream model.
module tb_mcm6576_dot_shifter;

  localparam int D = 8;
  localparam int N = 4;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_start = 1'b0;
  logic       frame_start = 1'b0;
  logic [6:0] rom_d;
  logic       inv;
  logic [5:0] char_col;
  logic [3:0] rs;
  logic       load;
  logic       video;
  logic       video_active;

  logic [6:0] rom_mem [64];
  logic       inv_mem [64];

  assign rom_d = rom_mem[char_col];
  assign inv   = inv_mem[char_col];

  always #5 clk = ~clk;

  mcm6576_dot_shifter #(
    .DOTS_PER_CHAR (D),
    .CHARS_PER_LINE(N),
    .ROWS_PER_CHAR (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .frame_start (frame_start),
    .rom_d       (rom_d),
    .inv         (inv),
    .char_col    (char_col),
    .rs          (rs),
    .load        (load),
    .video       (video),
    .video_active(video_active)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] rs_exp;

  typedef struct packed {
    logic [27:0] rom;
    logic [3:0]  inv;
    logic [31:0] exp_dots;
    logic [3:0]  exp_rs;
    logic        spur;
    logic        fs_end;
    logic        ls_end;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One character slot: ROM dots then a blank gap, inverted when the flag is set.
  function automatic logic [7:0] slot(input logic [6:0] r, input logic i);
    return {r, 1'b0} ^ {8{i}};
  endfunction

  function automatic logic [31:0] line_model(input logic [27:0] rom, input logic [3:0] invm);
    logic [31:0] m;
    for (int k = 0; k < N; k++) begin
      m[31-8*k -: 8] = slot(rom[27-7*k -: 7], invm[k]);
    end
    return m;
  endfunction

  task automatic run_line(input logic [27:0] rom, input logic [3:0] invm, input bit spur,
                          input int fs_cyc, input bit ls_end, output logic [31:0] dots);
    int          loads;
    logic [31:0] model;
    int          exp_col;
    bit          act_e;
    logic        exp_v;
    loads = 0;
    dots  = '0;
    model = line_model(rom, invm);
    for (int k = 0; k < N; k++) begin
      rom_mem[k] = rom[27-7*k -: 7];
      inv_mem[k] = invm[k];
    end
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    for (int m = 0; m < N*D + D; m++) begin
      act_e   = (m >= D);
      exp_v   = act_e ? model[31-(m-D)] : 1'b0;
      exp_col = (m / D > N) ? N : m / D;
      chk("video_active", video_active, act_e);
      chk("video", video, exp_v);
      chk("load", load, (m % D == D - 1) && (m < N*D));
      chk("char_col", char_col, exp_col);
      chk("rs", rs, rs_exp);
      if (act_e) dots[31-(m-D)] = video;
      if (load) loads++;
      line_start  = (spur && (m == 10 || m == N*D + 3)) || (ls_end && m == N*D + D - 1);
      frame_start = (m == fs_cyc);
      step();
      if (frame_start) rs_exp = 4'd0;
      else if (m == N*D + D - 1) rs_exp = (rs_exp == R - 1) ? 4'd0 : rs_exp + 4'd1;
      line_start  = 1'b0;
      frame_start = 1'b0;
    end
    chk("load_count", loads, N);
    chk("idle_active", video_active, 1'b0);
    chk("idle_col", char_col, 6'd0);
    chk("idle_rs", rs, rs_exp);
    if (ls_end) begin
      for (int c = 0; c < D + 2; c++) begin
        chk("ignored_ls_load", load, 1'b0);
        chk("ignored_ls_active", video_active, 1'b0);
        step();
      end
    end
  endtask

  initial begin
    logic [31:0] dots;
    logic [27:0] rrom;
    logic [3:0]  rinv;
    int          fs;

    for (int k = 0; k < 64; k++) begin
      rom_mem[k] = 7'h00;
      inv_mem[k] = 1'b0;
    end

    vecs[0] = '{rom: {4{7'h55}}, inv: 4'b0000, exp_dots: 32'hAAAAAAAA, exp_rs: 4'd1,
                spur: 1'b0, fs_end: 1'b0, ls_end: 1'b0};
    vecs[1] = '{rom: {4{7'h41}}, inv: 4'b0100, exp_dots: 32'h82827D82, exp_rs: 4'd2,
                spur: 1'b0, fs_end: 1'b0, ls_end: 1'b0};
    vecs[2] = '{rom: {7'h7F, 7'h00, 7'h55, 7'h2A}, inv: 4'b0001, exp_dots: 32'h0100AA54,
                exp_rs: 4'd0, spur: 1'b1, fs_end: 1'b0, ls_end: 1'b0};
    vecs[3] = '{rom: {7'h01, 7'h02, 7'h04, 7'h08}, inv: 4'b1111, exp_dots: 32'hFDFBF7EF,
                exp_rs: 4'd1, spur: 1'b0, fs_end: 1'b0, ls_end: 1'b1};
    vecs[4] = '{rom: {4{7'h55}}, inv: 4'b0000, exp_dots: 32'hAAAAAAAA, exp_rs: 4'd0,
                spur: 1'b0, fs_end: 1'b1, ls_end: 1'b0};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", video_active, 1'b0);
    chk("rst_video", video, 1'b0);
    chk("rst_col", char_col, 6'd0);
    chk("rst_rs", rs, 4'd0);
    chk("rst_load", load, 1'b0);
    rst = 1'b0;
    rs_exp = 4'd0;
    step();

    // Consecutive lines start in the first idle cycle after the previous drain.
    for (int i = 0; i < 5; i++) begin
      run_line(vecs[i].rom, vecs[i].inv, vecs[i].spur, vecs[i].fs_end ? N*D + D - 1 : -1,
               vecs[i].ls_end, dots);
      chk("vec_dots", dots, vecs[i].exp_dots);
      chk("vec_rs", rs, vecs[i].exp_rs);
    end

    run_line({4{7'h33}}, 4'b1010, 1'b0, -1, 1'b0, dots);
    chk("pre_reset_rs", rs, 4'd1);

    // Reset in the middle of a line.
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (15) step();
    chk("midline_col", char_col, 6'd1);
    chk("midline_active", video_active, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_active", video_active, 1'b0);
    chk("midrst_video", video, 1'b0);
    chk("midrst_col", char_col, 6'd0);
    chk("midrst_rs", rs, 4'd0);
    chk("midrst_load", load, 1'b0);
    rs_exp = 4'd0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 2*D; c++) begin
      chk("postrst_load", load, 1'b0);
      chk("postrst_active", video_active, 1'b0);
      chk("postrst_col", char_col, 6'd0);
      step();
    end

    for (int i = 0; i < 8; i++) begin
      rrom = 28'($urandom());
      rinv = 4'($urandom());
      fs   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N*D + D - 1)) : -1;
      run_line(rrom, rinv, 1'b0, fs, 1'b0, dots);
      chk("rand_dots", dots, line_model(rrom, rinv));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
